cnn_layer_sched: RTL

Layer-level sequencer for the CNN accelerator datapath.
- Waits for the clock-wizard `locked` signal.
- For each layer, drives the PE through two phases: weight load (weight_en), then compute (calculate_en).
- Between layers it toggles the ping-pong feature-map buffer select and presents the layer index and weight-ROM base address to the PE.
- Sits beside pe1 under the top level. A watchdog aborts any phase that hangs.

---
 rtl/cnn_pkg.sv | 28 ++
 rtl/sched_watchdog.sv | 38 +++
 rtl/cnn_layer_sched.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer sequencer.
// Holds the state codes and the per-layer weight-ROM base address table.
package cnn_pkg;

  localparam int NUM_LAYERS_MAX = 8;
  localparam int WBASE_W        = 14;

  typedef logic [2:0] sched_state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_LOAD_W    = 3'd2;
  localparam logic [2:0] ST_CALC      = 3'd3;
  localparam logic [2:0] ST_SWAP      = 3'd4;
  localparam logic [2:0] ST_FIN       = 3'd5;
  localparam logic [2:0] ST_ERR       = 3'd6;

  // Weight-ROM layout: each layer's filters start at these word offsets.
  localparam logic [WBASE_W-1:0] LAYER_WBASE [NUM_LAYERS_MAX] = '{
    14'h0000, 14'h0240, 14'h1680, 14'h2A00,
    14'h2F40, 14'h3280, 14'h35C0, 14'h3900
  };

  function automatic logic state_is_timed(input sched_state_t s);
    return (s == ST_WAIT_LOCK) || (s == ST_LOAD_W) || (s == ST_CALC);
  endfunction

endpackage

// File: rtl/sched_watchdog.sv
// Saturating phase watchdog for the layer sequencer.
// Flags expiry on the counted cycle whose increment lands on the all-ones terminal count.
module sched_watchdog #(
  parameter int TIMEOUT_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] TERM = '1;

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != TERM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A phase entered with a cleared counter therefore times out after 2^TIMEOUT_W-1 cycles.
  assign expired = count_en && (cnt_q == (TERM - 1'b1));

endmodule

// File: rtl/cnn_layer_sched.sv
// Layer-level sequencer: per layer, weight load then compute, then a ping-pong swap.
// All outputs are registered from the next-state decode so they change with the state.
module cnn_layer_sched
  import cnn_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int TIMEOUT_W  = 20,
  parameter int WADDR_W    = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               locked,
  input  logic               start,
  input  logic               abort,
  input  logic               weight_done,
  input  logic               calc_done,
  output logic               weight_en,
  output logic               calculate_en,
  output logic               initializing,
  output logic [2:0]         layer_idx,
  output logic [WADDR_W-1:0] wbase_addr,
  output logic               buf_sel,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [2:0] LAST_LAYER = 3'(NUM_LAYERS - 1);

  sched_state_t state_q, state_d;
  logic [2:0]   layer_q, layer_d;
  logic         buf_q, buf_d;

  logic               weight_en_q, calc_en_q, init_q, busy_q, done_q, err_q;
  logic [WADDR_W-1:0] wbase_q;

  logic wd_clear, wd_count, wd_expired;
  logic locked_lost;

  assign wd_count    = state_is_timed(state_q);
  assign wd_clear    = (state_d != state_q);
  assign locked_lost = !locked &&
                       ((state_q == ST_LOAD_W) || (state_q == ST_CALC) || (state_q == ST_SWAP));

  sched_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear),
    .count_en (wd_count),
    .expired  (wd_expired)
  );

  // Abort outranks lock loss, which outranks timeout, which outranks the PE handshakes.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    buf_d   = buf_q;
    if (abort) begin
      state_d = ST_IDLE;
      layer_d = '0;
      buf_d   = 1'b0;
    end else if (locked_lost) begin
      state_d = ST_ERR;
    end else if (wd_count && wd_expired) begin
      state_d = ST_ERR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            layer_d = '0;
            buf_d   = 1'b0;
            state_d = locked ? ST_LOAD_W : ST_WAIT_LOCK;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked) state_d = ST_LOAD_W;
        end
        ST_LOAD_W: begin
          if (weight_done) state_d = ST_CALC;
        end
        ST_CALC: begin
          if (calc_done) state_d = ST_SWAP;
        end
        ST_SWAP: begin
          buf_d = ~buf_q;
          if (layer_q == LAST_LAYER) begin
            state_d = ST_FIN;
          end else begin
            layer_d = layer_q + 3'd1;
            state_d = ST_LOAD_W;
          end
        end
        ST_FIN:  state_d = ST_IDLE;
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      layer_q     <= '0;
      buf_q       <= 1'b0;
      weight_en_q <= 1'b0;
      calc_en_q   <= 1'b0;
      init_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wbase_q     <= WADDR_W'(LAYER_WBASE[0]);
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      buf_q       <= buf_d;
      weight_en_q <= (state_d == ST_LOAD_W);
      calc_en_q   <= (state_d == ST_CALC);
      init_q      <= (state_d == ST_WAIT_LOCK) || (state_d == ST_LOAD_W);
      busy_q      <= (state_d != ST_IDLE) && (state_d != ST_ERR);
      done_q      <= (state_d == ST_FIN);
      err_q       <= (state_d == ST_ERR);
      wbase_q     <= WADDR_W'(LAYER_WBASE[layer_d]);
    end
  end

  assign weight_en    = weight_en_q;
  assign calculate_en = calc_en_q;
  assign initializing = init_q;
  assign layer_idx    = layer_q;
  assign wbase_addr   = wbase_q;
  assign buf_sel      = buf_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule
